replay_seq: RTL

REPLAY_SEQ -- requirements
Module: replay_seq

---
 rtl/replay_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/replay_seq.sv
// replay_seq: replays a recorded poke/expect command stream against a target.
// Each accepted command drives its poke values and then steps the target
// for one clock (tgt_en). Next, the live peek values are compared with the
// command's expected values.
//
// Optional feature: define REPLAY_SEQ_MASK_EN to add cmd_mask. This is a
// per-channel compare enable that is registered with each command.
//
// Ports:
//   clock, reset          sole clock; synchronous active-high reset
//   start                 begins a replay (IDLE only)
//   cmd_valid/cmd_ready   command handshake
//   cmd_poke/cmd_expect   per-step drive values / expected target outputs
//   cmd_last              final command of the replay
//   cmd_mask              (REPLAY_SEQ_MASK_EN) channels to compare
//   peek                  live target outputs
//   tgt_reset, tgt_en     target reset and single-step clock enable
//   poke                  registered drive values
//   cycles                target steps since leaving RST
//   mismatches            failing CHECK clocks, saturating
//   fail_cycle/fail_chan  step number and lowest channel of first mismatch
//   exit, pass, timeout   replay finished / clean / ended by MAX_CYCLES
module replay_seq #(
  parameter int NCHAN        = 4,
  parameter int DATA_W       = 32,
  parameter int CYCLE_W      = 65,
  parameter int RESET_CYCLES = 5,
  parameter int MAX_CYCLES   = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [NCHAN*DATA_W-1:0] cmd_poke,
  input  logic [NCHAN*DATA_W-1:0] cmd_expect,
  input  logic                    cmd_last,
`ifdef REPLAY_SEQ_MASK_EN
  input  logic [NCHAN-1:0]        cmd_mask,
`endif
  input  logic [NCHAN*DATA_W-1:0] peek,
  output logic                    tgt_reset,
  output logic                    tgt_en,
  output logic [NCHAN*DATA_W-1:0] poke,
  output logic [CYCLE_W-1:0]      cycles,
  output logic [15:0]             mismatches,
  output logic [CYCLE_W-1:0]      fail_cycle,
  output logic [4:0]              fail_chan,
  output logic                    exit,
  output logic                    pass,
  output logic                    timeout
);

  typedef enum logic [2:0] {IDLE, RST, RUN, STEP, CHECK, DONE} state_t;

  localparam logic [CYCLE_W-1:0] MAX_C = CYCLE_W'(MAX_CYCLES);

  state_t                  state;
  logic [31:0]             rst_cnt;
  logic [NCHAN*DATA_W-1:0] exp_r;
  logic                    last_r;
  logic [NCHAN-1:0]        mask_r;
  logic [NCHAN-1:0]        mask_in;
  logic [NCHAN-1:0]        chan_fail;
  logic                    any_fail;
  logic [4:0]              first_idx;
  logic [15:0]             mism_nxt;
  logic                    hit_max;

`ifdef REPLAY_SEQ_MASK_EN
  assign mask_in = cmd_mask;
`else
  assign mask_in = '1;
`endif

  for (genvar i = 0; i < NCHAN; i++) begin : g_cmp
    assign chan_fail[i] = mask_r[i] &&
                          (peek[i*DATA_W +: DATA_W] != exp_r[i*DATA_W +: DATA_W]);
  end

  assign any_fail = |chan_fail;

  // Scan from the top down so the lowest failing channel wins.
  always_comb begin
    first_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (chan_fail[i]) first_idx = 5'(i);
  end

  // A failing CHECK clock counts once, however many channels differ.
  assign mism_nxt = (any_fail && mismatches != 16'hFFFF) ? mismatches + 16'd1 : mismatches;
  assign hit_max  = (MAX_CYCLES != 0) && (cycles >= MAX_C);

  // Outputs are set on the transition into each state, so they are
  // valid for the whole time the FSM occupies that state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      exp_r      <= '0;
      last_r     <= 1'b0;
      mask_r     <= '0;
      tgt_reset  <= 1'b1;
      tgt_en     <= 1'b0;
      cmd_ready  <= 1'b0;
      poke       <= '0;
      cycles     <= '0;
      mismatches <= '0;
      fail_cycle <= '0;
      fail_chan  <= '0;
      exit       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= RST;
          rst_cnt    <= '0;
          cycles     <= '0;
          mismatches <= '0;
          fail_cycle <= '0;
          fail_chan  <= '0;
          timeout    <= 1'b0;
        end
        RST: begin
          if (rst_cnt == 32'(RESET_CYCLES - 1)) begin
            state     <= RUN;
            tgt_reset <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 32'd1;
          end
        end
        RUN: if (cmd_valid) begin
          state     <= STEP;
          poke      <= cmd_poke;
          exp_r     <= cmd_expect;
          last_r    <= cmd_last;
          mask_r    <= mask_in;
          cmd_ready <= 1'b0;
          tgt_en    <= 1'b1;
        end
        STEP: begin
          state  <= CHECK;
          tgt_en <= 1'b0;
          cycles <= cycles + CYCLE_W'(1);
        end
        CHECK: begin
          mismatches <= mism_nxt;
          if (any_fail && mismatches == 16'd0) begin
            fail_cycle <= cycles;
            fail_chan  <= first_idx;
          end
          // A timeout takes priority over a clean last command.
          if (last_r || hit_max) begin
            state   <= DONE;
            exit    <= 1'b1;
            timeout <= hit_max;
            pass    <= (mism_nxt == 16'd0) && !hit_max;
          end else begin
            state     <= RUN;
            cmd_ready <= 1'b1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
